// File: rtl/pcie_egress_seg_pkg.sv
// Shared PCIe egress definitions: dw0 field layout, fmt bit positions, 4 KB page size
// and the state encoding of the segmenting egress engine.
package pcie_egress_seg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIFO,
    CALC,
    HDR,
    DATA,
    FINISHED
  } state_t;

  localparam int DW0_CMD_MSB   = 31;
  localparam int DW0_CMD_LSB   = 24;
  localparam int DW0_FLAGS_MSB = 23;
  localparam int DW0_FLAGS_LSB = 10;
  localparam int DW0_LEN_MSB   = 9;
  localparam int DW0_LEN_LSB   = 0;

  // fmt[0] selects the 4-DW header, fmt[1] marks a TLP that carries data.
  localparam int FMT_4DW_BIT  = 29;
  localparam int FMT_DATA_BIT = 30;

  localparam int BOUNDARY_4K = 4096;

  localparam logic [7:0] BE_SINGLE = 8'h0F;
  localparam logic [7:0] BE_FULL   = 8'hFF;

  function automatic logic cmd_has_data(input logic [7:0] cmd);
    return cmd[FMT_DATA_BIT-DW0_CMD_LSB];
  endfunction

  function automatic logic [31:0] build_dw0(input logic [7:0]  cmd,
                                            input logic        four_dw,
                                            input logic [13:0] flags,
                                            input logic [9:0]  len);
    logic [31:0] dw;
    dw = '0;
    dw[DW0_CMD_MSB:DW0_CMD_LSB]     = cmd;
    dw[FMT_4DW_BIT]                 = four_dw;
    dw[DW0_FLAGS_MSB:DW0_FLAGS_LSB] = flags;
    dw[DW0_LEN_MSB:DW0_LEN_LSB]     = len;
    return dw;
  endfunction

endpackage

// File: rtl/pcie_egress_seg_len_calc.sv
// Segment length for the next write TLP: the smallest of the dwords still to send,
// the max payload size and the dwords left before the next 4 KB page.
module pcie_seg_len_calc
  import pcie_egress_seg_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int SIZE_WIDTH     = 24
) (
  input  logic [SIZE_WIDTH-1:0] remaining,
  input  logic [9:0]            addr_dw,
  output logic [10:0]           seg
);

  localparam int          CW      = (SIZE_WIDTH > 11) ? SIZE_WIDTH : 11;
  localparam logic [10:0] MPS_DW  = 11'(MAX_PAYLOAD_DW);
  localparam logic [10:0] PAGE_DW = 11'(BOUNDARY_4K / 4);

  logic [10:0] to_page;
  logic [10:0] cap;

  always_comb begin
    to_page = PAGE_DW - {1'b0, addr_dw};
    cap     = (MPS_DW < to_page) ? MPS_DW : to_page;
    seg     = (CW'(remaining) < CW'(cap)) ? 11'(CW'(remaining)) : cap;
  end

endmodule

// File: rtl/pcie_egress_seg.sv
// Host-bound PCIe egress engine: turns one MWr/MRd request into one or more TLPs on a
// 32-bit AXI-Stream port, splitting write payloads at max payload size and 4 KB pages.
module pcie_egress_seg
  import pcie_egress_seg_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int SIZE_WIDTH     = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  output logic                  o_finished,
  input  logic [7:0]            i_command,
  input  logic [13:0]           i_flags,
  input  logic [63:0]           i_address,
  input  logic [15:0]           i_requester_id,
  input  logic [7:0]            i_tag,
  input  logic [9:0]            i_req_dword_cnt,
  input  logic                  i_axi_egress_ready,
  output logic [31:0]           o_axi_egress_data,
  output logic [3:0]            o_axi_egress_keep,
  output logic                  o_axi_egress_last,
  output logic                  o_axi_egress_valid,
  input  logic                  i_fifo_rdy,
  output logic                  o_fifo_act,
  input  logic [SIZE_WIDTH-1:0] i_fifo_size,
  input  logic [31:0]           i_fifo_data,
  output logic                  o_fifo_stb,
  output logic [15:0]           o_tlp_count
);

  state_t state, state_nxt;

  logic [7:0]            cmd_q;
  logic [13:0]           flags_q;
  logic [15:0]           rid_q;
  logic [9:0]            rd_cnt_q;
  logic [63:0]           addr_q;
  logic [SIZE_WIDTH-1:0] remain_q;
  logic [7:0]            tag_q;
  logic [10:0]           seg_q;
  logic [1:0]            hdr_idx_q;
  logic [10:0]           data_cnt_q;
  logic                  fifo_act_q;
  logic [15:0]           tlp_count_q;

  logic [10:0] seg_calc;
  logic        is_write;
  logic        four_dw;
  logic        hdr_final;
  logic        data_final;
  logic [31:0] hdr_word;

  pcie_seg_len_calc #(
    .MAX_PAYLOAD_DW (MAX_PAYLOAD_DW),
    .SIZE_WIDTH     (SIZE_WIDTH)
  ) u_len_calc (
    .remaining (remain_q),
    .addr_dw   (addr_q[11:2]),
    .seg       (seg_calc)
  );

  assign is_write   = cmd_has_data(cmd_q);
  assign four_dw    = |addr_q[63:32];
  assign hdr_final  = (hdr_idx_q == (four_dw ? 2'd3 : 2'd2));
  assign data_final = (data_cnt_q == seg_q - 11'd1);

  always_comb begin
    hdr_word = '0;
    unique case (hdr_idx_q)
      2'd0:    hdr_word = build_dw0(cmd_q, four_dw, flags_q, seg_q[9:0]);
      2'd1:    hdr_word = {rid_q, tag_q, (seg_q == 11'd1) ? BE_SINGLE : BE_FULL};
      2'd2:    hdr_word = four_dw ? addr_q[63:32] : addr_q[31:0];
      default: hdr_word = addr_q[31:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_nxt          = state;
    o_axi_egress_valid = 1'b0;
    o_axi_egress_data  = '0;
    o_axi_egress_last  = 1'b0;
    o_fifo_stb         = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_enable) state_nxt = cmd_has_data(i_command) ? WAIT_FIFO : CALC;
      end
      WAIT_FIFO: begin
        if (i_fifo_rdy) state_nxt = (i_fifo_size == '0) ? FINISHED : CALC;
      end
      CALC: state_nxt = HDR;
      HDR: begin
        o_axi_egress_valid = 1'b1;
        o_axi_egress_data  = hdr_word;
        o_axi_egress_last  = hdr_final && !is_write;
        if (i_axi_egress_ready && hdr_final) state_nxt = is_write ? DATA : FINISHED;
      end
      DATA: begin
        o_axi_egress_valid = 1'b1;
        o_axi_egress_data  = i_fifo_data;
        o_axi_egress_last  = data_final;
        o_fifo_stb         = i_axi_egress_ready;
        if (i_axi_egress_ready && data_final)
          state_nxt = (remain_q == SIZE_WIDTH'(seg_q)) ? FINISHED : CALC;
      end
      FINISHED: begin
        if (!i_enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      flags_q     <= '0;
      rid_q       <= '0;
      rd_cnt_q    <= '0;
      addr_q      <= '0;
      remain_q    <= '0;
      tag_q       <= '0;
      seg_q       <= '0;
      hdr_idx_q   <= '0;
      data_cnt_q  <= '0;
      fifo_act_q  <= 1'b0;
      tlp_count_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_enable) begin
            cmd_q       <= i_command;
            flags_q     <= i_flags;
            rid_q       <= i_requester_id;
            rd_cnt_q    <= i_req_dword_cnt;
            addr_q      <= i_address;
            tag_q       <= i_tag;
            remain_q    <= '0;
            tlp_count_q <= '0;
          end
        end
        WAIT_FIFO: begin
          if (i_fifo_rdy) remain_q <= i_fifo_size;
        end
        CALC: begin
          // A read length of 0 stands for the full 1024 dwords.
          if (is_write)              seg_q <= seg_calc;
          else if (rd_cnt_q == '0)   seg_q <= 11'd1024;
          else                       seg_q <= {1'b0, rd_cnt_q};
          hdr_idx_q  <= '0;
          data_cnt_q <= '0;
        end
        HDR: begin
          if (i_axi_egress_ready) hdr_idx_q <= hdr_idx_q + 2'd1;
        end
        DATA: begin
          if (i_axi_egress_ready) begin
            data_cnt_q <= data_cnt_q + 11'd1;
            if (data_final) begin
              addr_q      <= addr_q + {51'd0, seg_q, 2'b00};
              remain_q    <= remain_q - SIZE_WIDTH'(seg_q);
              tag_q       <= tag_q + 8'd1;
              tlp_count_q <= tlp_count_q + 16'd1;
            end
          end
        end
        default: ;
      endcase

      if (state_nxt == FINISHED || state_nxt == IDLE) fifo_act_q <= 1'b0;
      else if (state == WAIT_FIFO && i_fifo_rdy)      fifo_act_q <= 1'b1;
    end
  end

  assign o_finished        = (state == FINISHED);
  assign o_fifo_act        = fifo_act_q;
  assign o_tlp_count       = tlp_count_q;
  assign o_axi_egress_keep = 4'hF;

endmodule

// File: tb/tb_pcie_egress_seg.sv
// Randomized bench for pcie_egress_seg: a transfer-level model builds the expected beat
// stream from the segmentation rules and a FWFT FIFO model feeds write payloads.
module tb_pcie_egress_seg;

  localparam int          MPS     = 32;
  localparam int          SW      = 24;
  localparam logic [7:0]  CMD_MWR = 8'h40;
  localparam logic [7:0]  CMD_MRD = 8'h00;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic          o_finished;
  logic [7:0]    i_command;
  logic [13:0]   i_flags;
  logic [63:0]   i_address;
  logic [15:0]   i_requester_id;
  logic [7:0]    i_tag;
  logic [9:0]    i_req_dword_cnt;
  logic          i_axi_egress_ready;
  logic [31:0]   o_axi_egress_data;
  logic [3:0]    o_axi_egress_keep;
  logic          o_axi_egress_last;
  logic          o_axi_egress_valid;
  logic          i_fifo_rdy;
  logic          o_fifo_act;
  logic [SW-1:0] i_fifo_size;
  logic [31:0]   i_fifo_data;
  logic          o_fifo_stb;
  logic [15:0]   o_tlp_count;

  always #5 clk = ~clk;

  pcie_egress_seg #(.MAX_PAYLOAD_DW(MPS), .SIZE_WIDTH(SW)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_enable           (i_enable),
    .o_finished         (o_finished),
    .i_command          (i_command),
    .i_flags            (i_flags),
    .i_address          (i_address),
    .i_requester_id     (i_requester_id),
    .i_tag              (i_tag),
    .i_req_dword_cnt    (i_req_dword_cnt),
    .i_axi_egress_ready (i_axi_egress_ready),
    .o_axi_egress_data  (o_axi_egress_data),
    .o_axi_egress_keep  (o_axi_egress_keep),
    .o_axi_egress_last  (o_axi_egress_last),
    .o_axi_egress_valid (o_axi_egress_valid),
    .i_fifo_rdy         (i_fifo_rdy),
    .o_fifo_act         (o_fifo_act),
    .i_fifo_size        (i_fifo_size),
    .i_fifo_data        (i_fifo_data),
    .o_fifo_stb         (o_fifo_stb),
    .o_tlp_count        (o_tlp_count)
  );

  typedef struct {
    logic [31:0] data;
    bit          last;
    bit          is_data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] words[$];
  int          exp_tlps;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_header(input logic [7:0] cmd, input logic [63:0] a, input int len,
                             input logic [7:0] tag, input logic [13:0] flags,
                             input logic [15:0] rid, input bit last_on_hdr);
    logic        four;
    logic [9:0]  len10;
    logic [7:0]  be;
    logic [31:0] dw0;
    four  = (a[63:32] != 32'd0);
    len10 = len[9:0];
    be    = (len == 1) ? 8'h0F : 8'hFF;
    dw0   = {cmd[7:6], four, cmd[4:0], flags, len10};
    exp_q.push_back('{dw0, 1'b0, 1'b0});
    exp_q.push_back('{{rid, tag, be}, 1'b0, 1'b0});
    if (four) begin
      exp_q.push_back('{a[63:32], 1'b0, 1'b0});
      exp_q.push_back('{a[31:0], last_on_hdr, 1'b0});
    end else begin
      exp_q.push_back('{a[31:0], last_on_hdr, 1'b0});
    end
  endtask

  task automatic build_model(input bit wr, input logic [63:0] addr, input int size,
                             input logic [9:0] rdcnt, input logic [7:0] tag,
                             input logic [13:0] flags, input logic [15:0] rid);
    logic [63:0] a;
    logic [7:0]  t;
    int          rem, seg, to_page;
    exp_q.delete();
    words.delete();
    exp_tlps = 0;
    if (!wr) begin
      push_header(CMD_MRD, addr, (rdcnt == 10'd0) ? 1024 : int'(rdcnt), tag, flags, rid, 1'b1);
      return;
    end
    rem = size;
    a   = addr;
    t   = tag;
    while (rem > 0) begin
      to_page = (4096 - int'(a[11:0])) / 4;
      seg = rem;
      if (seg > MPS)     seg = MPS;
      if (seg > to_page) seg = to_page;
      push_header(CMD_MWR, a, seg, t, flags, rid, 1'b0);
      for (int j = 0; j < seg; j++) begin
        logic [31:0] w;
        w = $urandom;
        words.push_back(w);
        exp_q.push_back('{w, (j == seg - 1), 1'b1});
      end
      a   = a + 64'(seg * 4);
      rem = rem - seg;
      t   = t + 8'd1;
      exp_tlps++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_enable = 1'b0;
    i_fifo_rdy = 1'b0;
    i_axi_egress_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready toggles every cycle, 2: random ready
  task automatic run_xfer(input string name, input bit wr, input logic [63:0] addr,
                          input int size, input logic [9:0] rdcnt, input int mode);
    logic [7:0]  tag;
    logic [13:0] flags;
    logic [15:0] rid;
    logic [31:0] prev_data;
    bit          prev_last, prev_stall, done;
    int          k, widx, cyc, lasts, exp_lasts, first;
    tag = 8'($urandom);
    flags = 14'($urandom);
    rid = 16'($urandom);
    build_model(wr, addr, size, rdcnt, tag, flags, rid);
    exp_lasts = 0;
    foreach (exp_q[i]) if (exp_q[i].last) exp_lasts++;
    k = 0; widx = 0; cyc = 0; lasts = 0; first = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; done = 1'b0;

    @(negedge clk);
    i_enable        = 1'b1;
    i_command       = wr ? CMD_MWR : CMD_MRD;
    i_flags         = flags;
    i_address       = addr;
    i_requester_id  = rid;
    i_tag           = tag;
    i_req_dword_cnt = rdcnt;
    i_fifo_rdy      = wr;
    i_fifo_size     = SW'(size);
    i_fifo_data     = (words.size() > 0) ? words[0] : 32'hDEAD_BEEF;

    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       i_axi_egress_ready = 1'b1;
        1:       i_axi_egress_ready = cyc[0];
        default: i_axi_egress_ready = 1'($urandom);
      endcase
      i_fifo_data = (widx < words.size()) ? words[widx] : 32'hDEAD_BEEF;
      #1;
      if (prev_stall) begin
        check({name, ":hold_valid"}, o_axi_egress_valid, 1'b1);
        check({name, ":hold_data"}, o_axi_egress_data, prev_data);
        check({name, ":hold_last"}, o_axi_egress_last, prev_last);
      end
      if (!wr) check({name, ":mrd_act"}, o_fifo_act, 1'b0);
      else if (o_axi_egress_valid) check({name, ":act"}, o_fifo_act, 1'b1);
      if (o_axi_egress_valid && i_axi_egress_ready) begin
        if (first < 0) first = cyc;
        if (k < exp_q.size()) begin
          check($sformatf("%s:data%0d", name, k), o_axi_egress_data, exp_q[k].data);
          check($sformatf("%s:last%0d", name, k), o_axi_egress_last, exp_q[k].last);
          check($sformatf("%s:stb%0d", name, k), o_fifo_stb, exp_q[k].is_data);
        end else begin
          check({name, ":extra_beat"}, 1'b1, 1'b0);
        end
        if (o_axi_egress_last) lasts++;
        k++;
      end else begin
        check({name, ":stb_idle"}, o_fifo_stb, 1'b0);
      end
      if (o_fifo_stb) widx++;
      prev_stall = o_axi_egress_valid && !i_axi_egress_ready;
      prev_data  = o_axi_egress_data;
      prev_last  = o_axi_egress_last;
      if (o_finished) done = 1'b1;
    end

    check({name, ":finished"}, done, 1'b1);
    check({name, ":beats"}, k, exp_q.size());
    check({name, ":lasts"}, lasts, exp_lasts);
    check({name, ":keep"}, o_axi_egress_keep, 4'hF);
    if (wr) begin
      check({name, ":stbs"}, widx, size);
      check({name, ":tlp_count"}, o_tlp_count, exp_tlps);
      check({name, ":act_done"}, o_fifo_act, 1'b0);
    end
    if (mode == 0 && exp_q.size() > 0) check({name, ":latency"}, first, wr ? 3 : 2);

    @(negedge clk);
    i_enable   = 1'b0;
    i_fifo_rdy = 1'b0;
    @(negedge clk);
    #1;
    check({name, ":released"}, o_finished, 1'b0);
    if (!done) do_reset();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ":valid"}, o_axi_egress_valid, 1'b0);
    check({name, ":data"}, o_axi_egress_data, 32'd0);
    check({name, ":last"}, o_axi_egress_last, 1'b0);
    check({name, ":keep"}, o_axi_egress_keep, 4'hF);
    check({name, ":stb"}, o_fifo_stb, 1'b0);
    check({name, ":act"}, o_fifo_act, 1'b0);
    check({name, ":finished"}, o_finished, 1'b0);
    check({name, ":tlp_count"}, o_tlp_count, 16'd0);
  endtask

  task automatic run_reset_mid();
    int k, cyc;
    build_model(1'b1, 64'h3000, 40, 10'd0, 8'h10, 14'h0, 16'h1234);
    k = 0; cyc = 0;
    @(negedge clk);
    i_enable = 1'b1; i_command = CMD_MWR; i_flags = '0; i_address = 64'h3000;
    i_requester_id = 16'h1234; i_tag = 8'h10; i_req_dword_cnt = '0;
    i_fifo_rdy = 1'b1; i_fifo_size = SW'(40); i_axi_egress_ready = 1'b1;
    while (k < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      i_fifo_data = words[(k > 3) ? k - 3 : 0];
      #1;
      if (o_axi_egress_valid) k++;
    end
    check("rstmid:reached_data", k, 6);
    @(negedge clk);
    rst = 1'b1; i_enable = 1'b0; i_fifo_rdy = 1'b0; i_axi_egress_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    i_axi_egress_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rstmid:no_stb", o_fifo_stb, 1'b0);
      check("rstmid:no_valid", o_axi_egress_valid, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_enable = 1'b0; i_command = '0; i_flags = '0; i_address = '0;
    i_requester_id = '0; i_tag = '0; i_req_dword_cnt = '0;
    i_axi_egress_ready = 1'b0; i_fifo_rdy = 1'b0; i_fifo_size = '0; i_fifo_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_xfer("mwr_single",   1'b1, 64'h1000,        1,  10'd0,  0);
    run_xfer("mwr_mps",      1'b1, 64'h2000,        80, 10'd0,  0);
    run_xfer("mwr_4k",       1'b1, 64'h0FF0,        8,  10'd0,  0);
    run_xfer("mwr_4dw",      1'b1, 64'h1_0000_0000, 2,  10'd0,  0);
    run_xfer("mwr_toggle",   1'b1, 64'h5000,        5,  10'd0,  1);
    run_xfer("mwr_cross4g",  1'b1, 64'hFFFF_FFF0,   8,  10'd0,  0);
    run_xfer("mwr_empty",    1'b1, 64'h6000,        0,  10'd0,  0);
    run_xfer("mrd_16",       1'b0, 64'h4000,        0,  10'd16, 0);
    run_xfer("mrd_1024",     1'b0, 64'h2_0000_0040, 0,  10'd0,  1);
    run_xfer("mrd_1",        1'b0, 64'h7004,        0,  10'd1,  2);
    run_reset_mid();

    for (int n = 0; n < 25; n++) begin
      logic [63:0] a;
      bit          wr;
      a  = {($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 3)) : 32'd0, 32'($urandom)};
      a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'(4092 - 4 * $urandom_range(0, 40));
      wr = ($urandom_range(0, 3) != 0);
      run_xfer($sformatf("rand%0d", n), wr, a, $urandom_range(0, 100),
               10'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_egress_seg.md
# pcie_egress_seg

Parametrised successor to the single-TLP PCIe egress engine. It turns one host-bound transfer request (memory write from the outgoing FIFO, or memory read request) into one or more TLPs on the 32-bit AXI-Stream device-to-host port. Write payloads are split at `MAX_PAYLOAD_DW` and at 4 KB address boundaries. The 3-DW or 4-DW header is selected from the address, and the AXI `ready` handshake is honoured on every beat, header and data alike.

## Interface
- `MAX_PAYLOAD_DW`, 32, max payload dwords per TLP; power of two, 32..1024.
- `SIZE_WIDTH`, 24, width of FIFO transfer size.
- `clk` in 1 system clock.
- `rst` in 1 reset; one clock, synchronous, active-high.
- `i_enable` in 1 start request; level, held until `o_finished`.
- `o_finished` out 1 transfer done; held until `i_enable` low.
- `i_command` in 8 fmt/type (PCIe MWr or MRd, 32-bit form).
- `i_flags` in 14 header dw0 [23:10].
- `i_address` in 64 byte address, dword aligned.
- `i_requester_id` in 16 requester ID.
- `i_tag` in 8 first tag.
- `i_req_dword_cnt` in 10 MRd length (0 = 1024).
- `i_axi_egress_ready` in 1 core ready.
- `o_axi_egress_data` out 32 beat data.
- `o_axi_egress_keep` out 4 constant 4'hF.
- `o_axi_egress_last` out 1 final beat of the TLP.
- `o_axi_egress_valid` out 1 beat valid.
- `i_fifo_rdy` in 1 FIFO block available.
- `o_fifo_act` out 1 FIFO block owned.
- `i_fifo_size` in SIZE_WIDTH write dwords in block.
- `i_fifo_data` in 32 FWFT FIFO word.
- `o_fifo_stb` out 1 pop current word.
- `o_tlp_count` out 16 TLPs sent in this transfer.

## Operation
- Outputs at reset: all 0 except `o_axi_egress_keep` = 4'hF. State IDLE. FIFO ownership is released.
- States: IDLE, WAIT_FIFO, CALC, HDR, DATA, FINISHED.
- IDLE, `i_enable`=1:
  - MRd goes to CALC.
  - MWr goes to WAIT_FIFO.
  - Clears `o_tlp_count` and loads the working address, remaining count and tag.
- WAIT_FIFO, `i_fifo_rdy`=1: set `o_fifo_act`, then:
  - `i_fifo_size`==0: go to FINISHED with no TLP sent.
  - Otherwise: go to CALC.
- CALC (one cycle): compute `seg = min(remaining, MAX_PAYLOAD_DW, (4096 - addr[11:0])>>2)`. For MRd, `seg` = `i_req_dword_cnt`, one TLP only.
- Header dwords:
  - dw0 = {`i_command` with bit 29 forced to (addr[63:32]!=0), `i_flags`, seg[9:0]}. A length of 1024 is encoded as 0.
  - dw1 = {`i_requester_id`, tag, BE}. BE = 8'h0F if seg==1, else 8'hFF.
  - dw2/dw3 = addr[63:32], addr[31:0] for a 4-DW header; dw2 = addr[31:0] for a 3-DW header.
- HDR: sends the header beats. After the final header beat, MRd goes to FINISHED and MWr goes to DATA.
- DATA:
  - `o_axi_egress_data` = `i_fifo_data`.
  - `o_fifo_stb` = valid & ready, combinational per accepted beat.
  - After `seg` beats: addr += seg*4, remaining -= seg, tag += 1 (mod 256), `o_tlp_count` += 1.
  - Then go to CALC if remaining != 0, else FINISHED.
- FINISHED:
  - Drops `o_fifo_act`.
  - Sets `o_finished`.
  - Returns to IDLE when `i_enable`=0.
- Deassertion of `i_enable` before FINISHED is ignored.

## Timing
- AXI handshake:
  - A beat transfers on valid & ready.
  - Once valid is high, data and last stay stable until accepted.
  - Valid is never dropped mid-TLP.
  - Valid is low in CALC, so there is one idle cycle between TLPs.
- `o_axi_egress_last` is high exactly on the final beat of each TLP.
- Latency with ready held high:
  - MRd: first valid beat 2 cycles after `i_enable` is sampled.
  - MWr: first valid beat 2 cycles after `i_fifo_rdy` is sampled in WAIT_FIFO.
- Beats per TLP = header size + seg.
- Address arithmetic is 64-bit with carry into the upper word. Crossing 2^32 switches later TLPs to the 4-DW header.
- `rst` mid-transfer: the next cycle has all outputs at reset values and no further `o_fifo_stb`.

## Structure
- Shared defines header (existing PCIe defines):
  - dw0 field ranges.
  - MWr/MRd type codes.
  - fmt 4-DW bit index (29).
  - 4 KB boundary constant.
- Sub-module `pcie_seg_len_calc`: a combinational min of remaining, MPS and dwords-to-4KB. It is registered by the parent in CALC and tested separately.

## Test plan
- MWr at addr 0x1000, size 1, ready=1 → 4 beats [0x40000001 (flags 0), {id,tag,0x0F}, 0x1000, data], last on beat 4, one stb, `o_tlp_count`=1.
- MWr at 0x2000, size 80, MPS 32 → 3 TLPs with lengths 32/32/16 at 0x2000/0x2080/0x2100, tags t/t+1/t+2, 80 stbs, 3 last pulses.
- MWr at 0x0FF0, size 8 → TLP of len 4 at 0x0FF0, then TLP of len 4 at 0x1000.
- MWr at 0x1_0000_0000, size 2 → 4-DW header, dw0 bit 29=1, dw2=0x1, dw3=0x0, 6 beats.
- Ready toggling every cycle during MWr size 5 → data and last stable while stalled, stb only on accepted beats, exactly 5 stbs.
- MRd with dword_cnt 16 → 3 beats, last on beat 3, `o_fifo_act` never high. Then MWr with `rst` in DATA → all outputs 0 on the next cycle and state IDLE.
